// File: rtl/dualmem_arb_ctrl.sv
// Single-port RAM owner: round-robin sharing between a refill writer (r0) and a
// lookup reader (r1), plus a zero-fill sweep of the whole array.
module dualmem_arb_ctrl #(
  parameter int DATA_W         = 1260,
  parameter int ADDR_W         = 9,
  parameter int DEPTH          = 512,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear_req,
  output logic              busy,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {ST_CLEAR, ST_SERVE} state_e;

  localparam state_e            RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_SERVE;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ctr_q, ctr_d;
  logic                rr_q, rr_d;
  logic                rvalid0_q, rvalid0_d;
  logic                rvalid1_q, rvalid1_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= RESET_STATE;
      ctr_q     <= '0;
      rr_q      <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      rr_q      <= rr_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  // rr_q=0 prefers r0 on a tie; grants and RAM strobes are held off while rstn is low.
  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    rr_d      = rr_q;
    r0_gnt    = 1'b0;
    r1_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    unique case (state_q)
      ST_CLEAR: begin
        mem_en   = rstn;
        mem_we   = rstn;
        mem_addr = ctr_q;
        ctr_d    = ctr_q + 1'b1;
        if (ctr_q == LAST_ADDR) begin
          state_d = ST_SERVE;
          ctr_d   = '0;
        end
      end
      ST_SERVE: begin
        if (rstn) begin
          r0_gnt = r0_req && (!r1_req || !rr_q);
          r1_gnt = r1_req && (!r0_req || rr_q);
        end
        if (r0_gnt) begin
          mem_en    = 1'b1;
          mem_we    = r0_we;
          mem_addr  = r0_addr;
          mem_wdata = r0_wdata;
        end else if (r1_gnt) begin
          mem_en    = 1'b1;
          mem_we    = r1_we;
          mem_addr  = r1_addr;
          mem_wdata = r1_wdata;
        end
        if (r0_req && r1_req) begin
          rr_d = !rr_q;
        end
        if (clear_req) begin
          state_d = ST_CLEAR;
          ctr_d   = '0;
        end
      end
      default: state_d = RESET_STATE;
    endcase

    rvalid0_d = r0_gnt && !r0_we;
    rvalid1_d = r1_gnt && !r1_we;
  end

  assign busy      = (state_q == ST_CLEAR);
  assign r0_rvalid = rvalid0_q;
  assign r1_rvalid = rvalid1_q;
  assign r0_rdata  = mem_rdata;
  assign r1_rdata  = mem_rdata;

endmodule

// File: tb/tb_dualmem_arb_ctrl.sv
// Scoreboard bench for dualmem_arb_ctrl: a behavioural RAM and arbitration model
// predict grants, RAM strobes and read data; a negedge monitor compares.
module tb_dualmem_arb_ctrl;

  localparam int DATA_W = 1260;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;

  logic              clk = 1'b0;
  logic              rstn;
  logic              clearReq;
  logic              busy;
  logic              r0Req, r0We, r0Gnt, r0Rvalid;
  logic [ADDR_W-1:0] r0Addr;
  logic [DATA_W-1:0] r0Wdata, r0Rdata;
  logic              r1Req, r1We, r1Gnt, r1Rvalid;
  logic [ADDR_W-1:0] r1Addr;
  logic [DATA_W-1:0] r1Wdata, r1Rdata;
  logic              memEn, memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata, memRdata;

  // second instance, no reset sweep
  logic              rstn6;
  logic              s0Req, s0Gnt, s0Rvalid, busy6, s1Gnt, s1Rvalid, memEn6, memWe6;
  logic [ADDR_W-1:0] memAddr6;
  logic [DATA_W-1:0] s0Rdata, s1Rdata, memWdata6;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  dualmem_arb_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rstn(rstn), .clear_req(clearReq), .busy(busy),
    .r0_req(r0Req), .r0_we(r0We), .r0_addr(r0Addr), .r0_wdata(r0Wdata),
    .r0_gnt(r0Gnt), .r0_rvalid(r0Rvalid), .r0_rdata(r0Rdata),
    .r1_req(r1Req), .r1_we(r1We), .r1_addr(r1Addr), .r1_wdata(r1Wdata),
    .r1_gnt(r1Gnt), .r1_rvalid(r1Rvalid), .r1_rdata(r1Rdata),
    .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_rdata(memRdata)
  );

  dualmem_arb_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CLEAR_ON_RESET(1'b0)) dut6 (
    .clk(clk), .rstn(rstn6), .clear_req(1'b0), .busy(busy6),
    .r0_req(s0Req), .r0_we(1'b0), .r0_addr(9'd3), .r0_wdata('0),
    .r0_gnt(s0Gnt), .r0_rvalid(s0Rvalid), .r0_rdata(s0Rdata),
    .r1_req(1'b0), .r1_we(1'b0), .r1_addr('0), .r1_wdata('0),
    .r1_gnt(s1Gnt), .r1_rvalid(s1Rvalid), .r1_rdata(s1Rdata),
    .mem_en(memEn6), .mem_we(memWe6), .mem_addr(memAddr6), .mem_wdata(memWdata6),
    .mem_rdata('0)
  );

  // RAM behind the DUT port: registered read, one cycle latency
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (memEn) begin
      if (memWe) ram[memAddr] <= memWdata;
      else       memRdata     <= ram[memAddr];
    end
  end

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, required %h (low 64 bits)", name, act[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [DATA_W-1:0] randWord();
    logic [1279:0] t;
    for (int i = 0; i < 40; i++) t[i*32 +: 32] = $urandom;
    return t[DATA_W-1:0];
  endfunction

  // Reference model state: words written since the last sweep (absent means zero)
  logic [DATA_W-1:0] refMem [int];
  logic [DATA_W-1:0] q0 [$];
  logic [DATA_W-1:0] q1 [$];
  int  sweepLeft = DEPTH;
  int  sweepIdx = 0;
  bit  preferR1 = 1'b0;
  bit  expRv0 = 1'b0, expRv1 = 1'b0;

  function automatic logic [DATA_W-1:0] refRead(input int a);
    return refMem.exists(a) ? refMem[a] : '0;
  endfunction

  // Monitor: compare this cycle against the model, then advance the model one clock
  always @(negedge clk) begin
    bit e0, e1, inSweep;
    logic [DATA_W-1:0] expData;
    if (!rstn) begin
      checkOutput("reset busy", DATA_W'(busy), DATA_W'(1));
      checkOutput("reset gnt", DATA_W'({r0Gnt, r1Gnt}), '0);
      checkOutput("reset mem_en", DATA_W'({memEn, memWe}), '0);
      checkOutput("reset rvalid", DATA_W'({r0Rvalid, r1Rvalid}), '0);
      sweepLeft = DEPTH; sweepIdx = 0; preferR1 = 1'b0;
      expRv0 = 1'b0; expRv1 = 1'b0;
      q0.delete(); q1.delete(); refMem.delete();
    end else begin
      inSweep = (sweepLeft > 0);
      checkOutput("busy", DATA_W'(busy), DATA_W'(inSweep));
      checkOutput("r0 rvalid", DATA_W'(r0Rvalid), DATA_W'(expRv0));
      checkOutput("r1 rvalid", DATA_W'(r1Rvalid), DATA_W'(expRv1));
      if (expRv0 && q0.size() > 0) begin
        expData = q0.pop_front();
        if (r0Rvalid) checkOutput("r0 rdata", r0Rdata, expData);
      end
      if (expRv1 && q1.size() > 0) begin
        expData = q1.pop_front();
        if (r1Rvalid) checkOutput("r1 rdata", r1Rdata, expData);
      end

      e0 = 1'b0; e1 = 1'b0;
      if (!inSweep) begin
        if (r0Req && r1Req) begin e0 = !preferR1; e1 = preferR1; end
        else begin e0 = r0Req; e1 = r1Req; end
      end
      checkOutput("r0 gnt", DATA_W'(r0Gnt), DATA_W'(e0));
      checkOutput("r1 gnt", DATA_W'(r1Gnt), DATA_W'(e1));

      if (inSweep) begin
        checkOutput("sweep en/we", DATA_W'({memEn, memWe}), DATA_W'(2'b11));
        checkOutput("sweep addr", DATA_W'(memAddr), DATA_W'(sweepIdx));
        checkOutput("sweep wdata", memWdata, '0);
      end else if (e0 || e1) begin
        checkOutput("grant en/we", DATA_W'({memEn, memWe}), DATA_W'({1'b1, e0 ? r0We : r1We}));
        checkOutput("grant addr", DATA_W'(memAddr), DATA_W'(e0 ? r0Addr : r1Addr));
        if (e0 ? r0We : r1We) checkOutput("grant wdata", memWdata, e0 ? r0Wdata : r1Wdata);
      end else begin
        checkOutput("idle mem_en", DATA_W'(memEn), '0);
      end

      expRv0 = e0 && !r0We;
      expRv1 = e1 && !r1We;
      if (e0) begin
        if (r0We) refMem[int'(r0Addr)] = r0Wdata;
        else q0.push_back(refRead(int'(r0Addr)));
      end
      if (e1) begin
        if (r1We) refMem[int'(r1Addr)] = r1Wdata;
        else q1.push_back(refRead(int'(r1Addr)));
      end
      if (e0 && e1) begin
        testsRun++; testsFailed++;
        $display("[TB] FAIL model double grant: got 2 grants, required 1");
      end
      if (!inSweep && r0Req && r1Req) preferR1 = !preferR1;

      if (inSweep) begin
        sweepIdx++;
        sweepLeft--;
      end else if (clearReq) begin
        sweepLeft = DEPTH;
        sweepIdx = 0;
        refMem.delete();
      end
    end
  end

  // Raise a request, hold it until granted, then drop it right after the handshake edge
  task automatic applyStimulus(input int port, input logic we, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] data);
    bit got = 1'b0;
    if (port == 0) begin r0We = we; r0Addr = addr; r0Wdata = data; r0Req = 1'b1; end
    else           begin r1We = we; r1Addr = addr; r1Wdata = data; r1Req = 1'b1; end
    for (int c = 0; c < 2000 && !got; c++) begin
      @(negedge clk);
      got = (port == 0) ? r0Gnt : r1Gnt;
    end
    if (!got) begin
      testsRun++; testsFailed++;
      $display("[TB] FAIL grant timeout port %0d: gnt=0, required 1", port);
    end
    @(posedge clk); #1;
    if (port == 0) r0Req = 1'b0;
    else           r1Req = 1'b0;
  endtask

  task automatic waitIdle();
    bit idle = 1'b0;
    for (int c = 0; c < 2000 && !idle; c++) begin
      @(negedge clk);
      idle = !busy;
    end
    if (!idle) begin
      testsRun++; testsFailed++;
      $display("[TB] FAIL sweep timeout: busy=1, required 0");
    end
    @(posedge clk); #1;
  endtask

  task automatic pulseClear();
    clearReq = 1'b1;
    @(posedge clk); #1;
    clearReq = 1'b0;
  endtask

  // Second instance: no sweep, serves on the first clock after release
  initial begin
    rstn6 = 1'b0;
    s0Req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("t6 busy in reset", DATA_W'(busy6), '0);
    checkOutput("t6 gnt in reset", DATA_W'(s0Gnt), '0);
    @(posedge clk); #1;
    rstn6 = 1'b1;
    @(negedge clk);
    checkOutput("t6 busy", DATA_W'(busy6), '0);
    checkOutput("t6 gnt", DATA_W'(s0Gnt), DATA_W'(1));
    checkOutput("t6 mem_en", DATA_W'({memEn6, memWe6}), DATA_W'(2'b10));
    @(posedge clk); #1;
    s0Req = 1'b0;
    @(negedge clk);
    checkOutput("t6 rvalid", DATA_W'(s0Rvalid), DATA_W'(1));
    @(negedge clk);
    checkOutput("t6 rvalid low", DATA_W'(s0Rvalid), '0);
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [DATA_W-1:0] pattern;
    rstn = 1'b0; clearReq = 1'b0;
    r0Req = 1'b0; r0We = 1'b0; r0Addr = '0; r0Wdata = '0;
    r1Req = 1'b1; r1We = 1'b0; r1Addr = 9'd7; r1Wdata = '0;
    repeat (3) @(posedge clk); #1;
    rstn = 1'b1;

    // T1: held r1 read waits out the reset sweep
    applyStimulus(1, 1'b0, 9'd7, '0);

    // T2: write then read back, plus an unwritten address
    for (int i = 0; i < DATA_W / 8; i++) pattern[i*8 +: 8] = 8'hA5;
    applyStimulus(0, 1'b1, 9'd5, pattern);
    applyStimulus(1, 1'b0, 9'd5, '0);
    applyStimulus(1, 1'b0, 9'd300, '0);

    // T3: both requesters held continuously
    fork
      begin repeat (3) applyStimulus(0, 1'b1, 9'd20, randWord()); end
      begin repeat (3) applyStimulus(1, 1'b0, 9'd20, '0); end
    join

    // T4: read granted together with clear_req, second clear mid-sweep
    r1We = 1'b0; r1Addr = 9'd5; r1Req = 1'b1; clearReq = 1'b1;
    @(posedge clk); #1;
    r1Req = 1'b0; clearReq = 1'b0;
    repeat (100) @(posedge clk); #1;
    pulseClear();
    waitIdle();

    // T5: reset in the middle of a sweep
    pulseClear();
    repeat (199) @(posedge clk); #1;
    rstn = 1'b0;
    repeat (3) @(posedge clk); #1;
    rstn = 1'b1;
    waitIdle();

    // Randomised traffic from both requesters over a small address window
    fork
      begin
        for (int n = 0; n < 60; n++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          applyStimulus(0, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)), randWord());
        end
      end
      begin
        for (int n = 0; n < 60; n++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          applyStimulus(1, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)), randWord());
        end
      end
    join

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
